operand_entry_ctrl: RTL and testbench
=====================================

// Module: operand_entry_ctrl
// PURPOSE
//   Upstream operand-capture stage for the 4-bit adder/7-segment display block.
//   The user enters A, B and Cin in turn on one shared switch bank.
//   A debounced push-button advances the entry; a second button clears it.
//   Outputs registered A_out/B_out/Cin_out, an entry_state code for the display, and operands_valid.
// PARAMETERS
//   WIDTH            4        operand width (sw_data, A_out, B_out)
//   DEBOUNCE_CYCLES  500000   consecutive stable cycles to accept a key change (10 ms @ 50 MHz); min 1
//   CNT_W            $clog2(DEBOUNCE_CYCLES+1)  debounce counter width (derived, do not override)
// PORTS
//   CLOCK_50        in   1      system clock, all logic on rising edge
//   rst             in   1      asynchronous, active-high reset
//   sw_data         in   WIDTH  shared operand switches (asynchronous to clock)
//   sw_cin          in   1      carry-in switch (asynchronous)
//   key_next_n      in   1      "next" push-button, active-low, bouncy
//   key_clear_n     in   1      "clear" push-button, active-low, bouncy
//   A_out           out  WIDTH  captured operand A
//   B_out           out  WIDTH  captured operand B
//   Cin_out         out  1      captured carry-in
//   operands_valid  out  1      high while A, B and Cin are all captured (state S_DONE)
//   entry_state     out  2      0=S_A, 1=S_B, 2=S_CIN, 3=S_DONE; drives the "next operand" prompt
// BEHAVIOUR
//   Reset (async assert, sync release):
//   - A_out=0, B_out=0, Cin_out=0, operands_valid=0, entry_state=S_A.
//   - Key sync flops and debounced key levels = 1 (released); switch sync flops = 0; counters = 0.
//   Synchronisation:
//   - Every input passes through a 2-flop synchroniser.
//   - Only synchronised values are used downstream.
//   Debounce (one instance per key):
//   - counter increments each cycle the sync level differs from the debounced level.
//   - counter clears to 0 on any cycle the levels match.
//   - When the counter reaches DEBOUNCE_CYCLES-1 and the levels still differ:
//     the debounced level takes the sync level and the counter clears.
//   - Glitches shorter than DEBOUNCE_CYCLES are ignored.
//   - Press event: a one-cycle pulse on a debounced 1->0 transition.
//   - Release (0->1) generates no event. A held key yields exactly one event.
//   Latency:
//   - The press pulse asserts DEBOUNCE_CYCLES+2 cycles after key_n is first sampled low and held.
//   - Captured outputs and entry_state update on the next edge: DEBOUNCE_CYCLES+3 cycles total.
//   - sw_data/sw_cin are taken from their synchronised values in the pulse cycle.
//   FSM (advances on next_press):
//   - S_A:    A_out <= sw_data,  -> S_B
//   - S_B:    B_out <= sw_data,  -> S_CIN
//   - S_CIN:  Cin_out <= sw_cin, -> S_DONE; operands_valid <= 1
//   - S_DONE: -> S_A; operands_valid <= 0; A/B/Cin retain their values until overwritten
//   - No press: state and outputs hold. Switch changes never affect captured values.
//   Clear (clear_press):
//   - In any state: -> S_A; A_out, B_out, Cin_out <= 0; operands_valid <= 0.
//   - Simultaneous clear_press and next_press: clear wins; next is discarded.
//   Reset mid-debounce or mid-entry:
//   - Returns to the reset values above.
//   - A key still held at reset release must be seen released, then pressed, before it counts.
//   Arithmetic:
//   - No arithmetic here; the sum is computed downstream.
//   - All outputs are registered with no combinational input-to-output path.
// TESTING (bench uses DEBOUNCE_CYCLES=4)
//   1 Reset, then sw_data=4'h5 and press next; sw_data=4'hA and press next; sw_cin=1 and press next
//     -> A_out=5, B_out=A, Cin_out=1, entry_state=3, operands_valid=1.
//   2 key_next_n low for 3 cycles, high, then low again for 3 cycles
//     -> no event; entry_state stays 0.
//   3 key_next_n held low 50 cycles
//     -> exactly one advance, A_out updates 7 cycles after the first low sample.
//   4 In S_DONE press next
//     -> entry_state=0, operands_valid=0, A_out/B_out/Cin_out unchanged.
//   5 In S_B, debounced next and clear pulses in the same cycle
//     -> entry_state=0, all operands 0, valid 0.
//   6 Assert rst mid-debounce in S_CIN with key held
//     -> all outputs 0 at once; no advance until the key is released and pressed again.

Source files
------------

// File: rtl/operand_entry_ctrl.sv
// Operand entry for the 4-bit adder: synchronises switches and keys, debounces the
// next/clear buttons and steps through A -> B -> Cin -> done, capturing one operand per press.
module operand_entry_ctrl #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic             CLOCK_50,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_data,
  input  logic             sw_cin,
  input  logic             key_next_n,
  input  logic             key_clear_n,
  output logic [WIDTH-1:0] A_out,
  output logic [WIDTH-1:0] B_out,
  output logic             Cin_out,
  output logic             operands_valid,
  output logic [1:0]       entry_state
);

  typedef enum logic [1:0] {S_A = 2'd0, S_B = 2'd1, S_CIN = 2'd2, S_DONE = 2'd3} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Key index 0 = next, 1 = clear.
  logic [1:0]       key_s1_q, key_s2_q;
  logic [WIDTH-1:0] sw_s1_q, sw_s2_q;
  logic             cin_s1_q, cin_s2_q;
  logic [1:0]       sync_ok_q, sync_ok_d;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];
  logic [1:0]       deb_q, deb_d;
  logic [1:0]       deb_prev_q, deb_prev_d;
  logic [1:0]       arm_q, arm_d;
  logic [1:0]       press_q, press_d;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             cin_q, cin_d, valid_q, valid_d;

  logic next_press, clear_press;
  assign next_press  = press_q[0];
  assign clear_press = press_q[1];

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      key_s1_q   <= 2'b11;
      key_s2_q   <= 2'b11;
      sw_s1_q    <= '0;
      sw_s2_q    <= '0;
      cin_s1_q   <= 1'b0;
      cin_s2_q   <= 1'b0;
      sync_ok_q  <= 2'b00;
      deb_q      <= 2'b11;
      deb_prev_q <= 2'b11;
      arm_q      <= 2'b00;
      press_q    <= 2'b00;
      for (int k = 0; k < 2; k++) cnt_q[k] <= '0;
    end else begin
      key_s1_q   <= {key_clear_n, key_next_n};
      key_s2_q   <= key_s1_q;
      sw_s1_q    <= sw_data;
      sw_s2_q    <= sw_s1_q;
      cin_s1_q   <= sw_cin;
      cin_s2_q   <= cin_s1_q;
      sync_ok_q  <= sync_ok_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      arm_q      <= arm_d;
      press_q    <= press_d;
      for (int k = 0; k < 2; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  // sync_ok marks when the key synchronisers hold real samples rather than reset values;
  // a key is armed only once it has been seen released, so one held through reset never fires.
  always_comb begin
    sync_ok_d  = {sync_ok_q[0], 1'b1};
    deb_d      = deb_q;
    deb_prev_d = deb_q;
    arm_d      = arm_q;
    press_d    = 2'b00;
    for (int k = 0; k < 2; k++) begin
      cnt_d[k] = '0;
      if (key_s2_q[k] != deb_q[k]) begin
        if (cnt_q[k] == CNT_MAX) deb_d[k] = key_s2_q[k];
        else                     cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end
      if (sync_ok_q[1] && key_s2_q[k]) arm_d[k] = 1'b1;
      press_d[k] = arm_q[k] & deb_prev_q[k] & ~deb_q[k];
    end
  end

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      state_q <= S_A;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear_press) state_d = S_A;
    else if (next_press) begin
      case (state_q)
        S_A:     state_d = S_B;
        S_B:     state_d = S_CIN;
        S_CIN:   state_d = S_DONE;
        default: state_d = S_A;
      endcase
    end
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    valid_d = valid_q;
    if (clear_press) begin
      a_d     = '0;
      b_d     = '0;
      cin_d   = 1'b0;
      valid_d = 1'b0;
    end else if (next_press) begin
      case (state_q)
        S_A:     a_d = sw_s2_q;
        S_B:     b_d = sw_s2_q;
        S_CIN: begin
          cin_d   = cin_s2_q;
          valid_d = 1'b1;
        end
        default: valid_d = 1'b0;
      endcase
    end
  end

  assign A_out          = a_q;
  assign B_out          = b_q;
  assign Cin_out        = cin_q;
  assign operands_valid = valid_q;
  assign entry_state    = state_q;

endmodule

// File: tb/tb_operand_entry_ctrl.sv
// Directed bench for operand_entry_ctrl with a short debounce window (4 cycles).
module tb_operand_entry_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sw_data;
  logic       sw_cin;
  logic       key_next_n;
  logic       key_clear_n;
  logic [3:0] A_out;
  logic [3:0] B_out;
  logic       Cin_out;
  logic       operands_valid;
  logic [1:0] entry_state;

  int vectors     = 0;
  int miscompares = 0;

  operand_entry_ctrl #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
    .CLOCK_50       (clk),
    .rst            (rst),
    .sw_data        (sw_data),
    .sw_cin         (sw_cin),
    .key_next_n     (key_next_n),
    .key_clear_n    (key_clear_n),
    .A_out          (A_out),
    .B_out          (B_out),
    .Cin_out        (Cin_out),
    .operands_valid (operands_valid),
    .entry_state    (entry_state)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_next();
    key_next_n = 1'b0;
    tick(10);
    key_next_n = 1'b1;
    tick(10);
  endtask

  task automatic press_clear();
    key_clear_n = 1'b0;
    tick(10);
    key_clear_n = 1'b1;
    tick(10);
  endtask

  task automatic test_reset();
    rst = 1'b1; sw_data = 4'h0; sw_cin = 1'b0; key_next_n = 1'b1; key_clear_n = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(5);
    vectors++; if (A_out !== 4'h0) begin miscompares++; $display("FAIL reset_a: got %h want 0", A_out); end
    vectors++; if (B_out !== 4'h0) begin miscompares++; $display("FAIL reset_b: got %h want 0", B_out); end
    vectors++; if (Cin_out !== 1'b0) begin miscompares++; $display("FAIL reset_cin: got %b want 0", Cin_out); end
    vectors++; if (operands_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", operands_valid); end
    vectors++; if (entry_state !== 2'd0) begin miscompares++; $display("FAIL reset_state: got %0d want 0", entry_state); end
  endtask

  task automatic test_glitch();
    sw_data = 4'hC;
    tick(3);
    key_next_n = 1'b0; tick(3);
    key_next_n = 1'b1; tick(1);
    key_next_n = 1'b0; tick(3);
    key_next_n = 1'b1; tick(10);
    vectors++; if (entry_state !== 2'd0) begin miscompares++; $display("FAIL glitch_state: got %0d want 0", entry_state); end
    vectors++; if (A_out !== 4'h0) begin miscompares++; $display("FAIL glitch_a: got %h want 0", A_out); end
  endtask

  task automatic test_hold_latency();
    sw_data = 4'h3;
    tick(3);
    key_next_n = 1'b0;
    tick(7);
    vectors++; if (A_out !== 4'h0) begin miscompares++; $display("FAIL hold_a_early: got %h want 0", A_out); end
    vectors++; if (entry_state !== 2'd0) begin miscompares++; $display("FAIL hold_state_early: got %0d want 0", entry_state); end
    tick(1);
    vectors++; if (A_out !== 4'h3) begin miscompares++; $display("FAIL hold_a_at7: got %h want 3", A_out); end
    vectors++; if (entry_state !== 2'd1) begin miscompares++; $display("FAIL hold_state_at7: got %0d want 1", entry_state); end
    tick(42);
    key_next_n = 1'b1;
    tick(10);
    vectors++; if (entry_state !== 2'd1) begin miscompares++; $display("FAIL hold_single_event: got %0d want 1", entry_state); end
    press_clear();
    vectors++; if (entry_state !== 2'd0) begin miscompares++; $display("FAIL clear_state: got %0d want 0", entry_state); end
    vectors++; if (A_out !== 4'h0) begin miscompares++; $display("FAIL clear_a: got %h want 0", A_out); end
  endtask

  task automatic test_full_entry();
    sw_data = 4'h5; tick(3); press_next();
    vectors++; if (A_out !== 4'h5) begin miscompares++; $display("FAIL entry_a: got %h want 5", A_out); end
    vectors++; if (entry_state !== 2'd1) begin miscompares++; $display("FAIL entry_state_b: got %0d want 1", entry_state); end
    sw_data = 4'hA; tick(3); press_next();
    vectors++; if (B_out !== 4'hA) begin miscompares++; $display("FAIL entry_b: got %h want a", B_out); end
    vectors++; if (entry_state !== 2'd2) begin miscompares++; $display("FAIL entry_state_cin: got %0d want 2", entry_state); end
    vectors++; if (operands_valid !== 1'b0) begin miscompares++; $display("FAIL entry_valid_early: got %b want 0", operands_valid); end
    sw_cin = 1'b1; tick(3); press_next();
    vectors++; if (Cin_out !== 1'b1) begin miscompares++; $display("FAIL entry_cin: got %b want 1", Cin_out); end
    vectors++; if (entry_state !== 2'd3) begin miscompares++; $display("FAIL entry_state_done: got %0d want 3", entry_state); end
    vectors++; if (operands_valid !== 1'b1) begin miscompares++; $display("FAIL entry_valid: got %b want 1", operands_valid); end
    sw_data = 4'hF; sw_cin = 1'b0; tick(5);
    vectors++; if (A_out !== 4'h5 || B_out !== 4'hA || Cin_out !== 1'b1) begin
      miscompares++; $display("FAIL entry_sw_isolation: got %h/%h/%b want 5/a/1", A_out, B_out, Cin_out);
    end
  endtask

  task automatic test_done_wrap();
    sw_data = 4'h7; tick(3); press_next();
    vectors++; if (entry_state !== 2'd0) begin miscompares++; $display("FAIL wrap_state: got %0d want 0", entry_state); end
    vectors++; if (operands_valid !== 1'b0) begin miscompares++; $display("FAIL wrap_valid: got %b want 0", operands_valid); end
    vectors++; if (A_out !== 4'h5 || B_out !== 4'hA || Cin_out !== 1'b1) begin
      miscompares++; $display("FAIL wrap_retain: got %h/%h/%b want 5/a/1", A_out, B_out, Cin_out);
    end
  endtask

  task automatic test_clear_priority();
    sw_data = 4'h2; tick(3); press_next();
    vectors++; if (entry_state !== 2'd1 || A_out !== 4'h2) begin
      miscompares++; $display("FAIL prio_setup: got state %0d a %h want 1/2", entry_state, A_out);
    end
    key_next_n = 1'b0; key_clear_n = 1'b0;
    tick(10);
    vectors++; if (entry_state !== 2'd0) begin miscompares++; $display("FAIL prio_state: got %0d want 0", entry_state); end
    vectors++; if (A_out !== 4'h0 || B_out !== 4'h0 || Cin_out !== 1'b0) begin
      miscompares++; $display("FAIL prio_operands: got %h/%h/%b want 0/0/0", A_out, B_out, Cin_out);
    end
    vectors++; if (operands_valid !== 1'b0) begin miscompares++; $display("FAIL prio_valid: got %b want 0", operands_valid); end
    key_next_n = 1'b1; key_clear_n = 1'b1;
    tick(10);
  endtask

  task automatic test_reset_mid();
    sw_data = 4'h9; tick(3); press_next();
    sw_data = 4'h6; tick(3); press_next();
    vectors++; if (entry_state !== 2'd2) begin miscompares++; $display("FAIL rmid_setup: got %0d want 2", entry_state); end
    key_next_n = 1'b0;
    tick(3);
    rst = 1'b1;
    #1;
    vectors++; if (A_out !== 4'h0 || B_out !== 4'h0 || Cin_out !== 1'b0) begin
      miscompares++; $display("FAIL rmid_async_operands: got %h/%h/%b want 0/0/0", A_out, B_out, Cin_out);
    end
    vectors++; if (entry_state !== 2'd0 || operands_valid !== 1'b0) begin
      miscompares++; $display("FAIL rmid_async_state: got %0d/%b want 0/0", entry_state, operands_valid);
    end
    tick(3);
    rst = 1'b0;
    tick(20);
    vectors++; if (entry_state !== 2'd0) begin miscompares++; $display("FAIL rmid_held_key: got %0d want 0", entry_state); end
    key_next_n = 1'b1;
    tick(10);
    vectors++; if (entry_state !== 2'd0) begin miscompares++; $display("FAIL rmid_release: got %0d want 0", entry_state); end
    sw_data = 4'h4; tick(3); press_next();
    vectors++; if (entry_state !== 2'd1 || A_out !== 4'h4) begin
      miscompares++; $display("FAIL rmid_repress: got state %0d a %h want 1/4", entry_state, A_out);
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_hold_latency();
    test_full_entry();
    test_done_wrap();
    test_clear_priority();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
